// File: rtl/eco_equiv_sweeper.sv
// Exhaustive equivalence sweeper: walks every {a,b} vector into a golden/revised
// netlist pair, samples both results after a settle time and records mismatches.
module eco_equiv_sweeper #(
    parameter int W      = 3,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     a_out,
    output logic [W-1:0]     b_out,
    input  logic [W-1:0]     y_in,
    input  logic [W-1:0]     y_ref_in,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     mismatch_cnt,
    output logic             first_fail_valid,
    output logic [W-1:0]     first_fail_a,
    output logic [W-1:0]     first_fail_b,
    output logic [W-1:0]     first_fail_diff
);

    localparam int IW = 2 * W;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t          state_reg, state_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [SW-1:0]   settle_reg, settle_next;
    logic [IW:0]     cnt_reg, cnt_next;
    logic            ff_valid_reg, ff_valid_next;
    logic [W-1:0]    ff_a_reg, ff_a_next;
    logic [W-1:0]    ff_b_reg, ff_b_next;
    logic [W-1:0]    ff_diff_reg, ff_diff_next;
    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            start_ok;
    logic            vec_mismatch;

    assign start_ok     = start && (state_reg == IDLE || state_reg == DONE);
    assign vec_mismatch = (y_in != y_ref_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            settle_reg   <= '0;
            cnt_reg      <= '0;
            ff_valid_reg <= 1'b0;
            ff_a_reg     <= '0;
            ff_b_reg     <= '0;
            ff_diff_reg  <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            settle_reg   <= settle_next;
            cnt_reg      <= cnt_next;
            ff_valid_reg <= ff_valid_next;
            ff_a_reg     <= ff_a_next;
            ff_b_reg     <= ff_b_next;
            ff_diff_reg  <= ff_diff_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = DRIVE;
            DRIVE:      if (settle_reg == SW'(SETTLE - 1)) state_next = SAMPLE;
            SAMPLE:     state_next = (&idx_reg) ? DONE : DRIVE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        idx_next      = idx_reg;
        settle_next   = settle_reg;
        cnt_next      = cnt_reg;
        ff_valid_next = ff_valid_reg;
        ff_a_next     = ff_a_reg;
        ff_b_next     = ff_b_reg;
        ff_diff_next  = ff_diff_reg;
        if (start_ok) begin
            idx_next      = '0;
            settle_next   = '0;
            cnt_next      = '0;
            ff_valid_next = 1'b0;
            ff_a_next     = '0;
            ff_b_next     = '0;
            ff_diff_next  = '0;
        end else if (state_reg == DRIVE) begin
            settle_next = settle_reg + 1'b1;
        end else if (state_reg == SAMPLE) begin
            if (vec_mismatch) begin
                cnt_next = cnt_reg + 1'b1;
                // Only the earliest failing vector is kept for debug.
                if (!ff_valid_reg) begin
                    ff_valid_next = 1'b1;
                    ff_a_next     = idx_reg[IW-1:W];
                    ff_b_next     = idx_reg[W-1:0];
                    ff_diff_next  = y_in ^ y_ref_in;
                end
            end
            if (!(&idx_reg)) begin
                idx_next    = idx_reg + 1'b1;
                settle_next = '0;
            end
        end
        busy_next = (state_next == DRIVE) || (state_next == SAMPLE);
        done_next = (state_next == DONE);
    end

    assign a_out            = idx_reg[IW-1:W];
    assign b_out            = idx_reg[W-1:0];
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign mismatch_cnt     = cnt_reg;
    assign first_fail_valid = ff_valid_reg;
    assign first_fail_a     = ff_a_reg;
    assign first_fail_b     = ff_b_reg;
    assign first_fail_diff  = ff_diff_reg;

endmodule

// File: tb/tb_eco_equiv_sweeper.sv
// Bench for eco_equiv_sweeper: a golden adder plus a per-vector fault table forms
// the revised netlist; expectations come from scanning that table directly.
module tb_eco_equiv_sweeper;

    localparam int W      = 3;
    localparam int SETTLE = 2;
    localparam int NV     = 1 << (2 * W);
    localparam int SWEEP  = NV * (SETTLE + 1);

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   a_out, b_out, y_in, y_ref_in;
    logic           busy, done, first_fail_valid;
    logic [2*W:0]   mismatch_cnt;
    logic [W-1:0]   first_fail_a, first_fail_b, first_fail_diff;
    logic [W-1:0]   fault_tab [NV];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    assign y_ref_in = a_out + b_out;
    assign y_in     = y_ref_in ^ fault_tab[{a_out, b_out}];

    eco_equiv_sweeper #(.W(W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start),
        .a_out(a_out), .b_out(b_out), .y_in(y_in), .y_ref_in(y_ref_in),
        .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_a(first_fail_a),
        .first_fail_b(first_fail_b), .first_fail_diff(first_fail_diff)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_faults(input int mode);
        for (int i = 0; i < NV; i++) begin
            case (mode)
                0: fault_tab[i] = '0;
                1: fault_tab[i] = (i == ((5 << W) | 2)) ? 3'b001 : 3'b000;
                2: fault_tab[i] = 3'b100;
                default: fault_tab[i] = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            endcase
        end
    endtask

    task automatic check_reset_values(input string name);
        compared++;
        if (a_out !== 0 || b_out !== 0 || busy !== 0 || done !== 0 || mismatch_cnt !== 0 ||
            first_fail_valid !== 0 || first_fail_a !== 0 || first_fail_b !== 0 || first_fail_diff !== 0) begin
            mismatched++;
            $display("FAIL %s: a=%0d b=%0d busy=%0b done=%0b cnt=%0d ffv=%0b ffa=%0d ffb=%0d ffd=%0d, required all zero",
                     name, a_out, b_out, busy, done, mismatch_cnt, first_fail_valid,
                     first_fail_a, first_fail_b, first_fail_diff);
        end
    endtask

    // Start a sweep and run it to DONE; repulse_at (>0) pulses start at that edge number.
    task automatic run_sweep(input string name, input int repulse_at);
        int n;
        int exp_cnt;
        int first;
        int k;
        logic bad_vec;
        exp_cnt = 0;
        first   = -1;
        for (int i = 0; i < NV; i++) begin
            if (fault_tab[i] != 0) begin
                exp_cnt++;
                if (first < 0) first = i;
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        compared++;
        if (busy !== 1 || done !== 0 || mismatch_cnt !== 0 || first_fail_valid !== 0 || a_out !== 0 || b_out !== 0) begin
            mismatched++;
            $display("FAIL %s_start: busy=%0b done=%0b cnt=%0d ffv=%0b a=%0d b=%0d, required busy=1 done=0 cnt=0 ffv=0 a=0 b=0",
                     name, busy, done, mismatch_cnt, first_fail_valid, a_out, b_out);
        end
        bad_vec = 1'b0;
        while (!done && n < SWEEP + 20) begin
            start = (repulse_at > 0 && n + 1 == repulse_at);
            tick();
            start = 1'b0;
            n++;
            k = n / (SETTLE + 1);
            if (!done && !bad_vec && ({a_out, b_out} !== (2*W)'(k) || busy !== 1)) begin
                bad_vec = 1'b1;
                $display("FAIL %s_vector: edge %0d a=%0d b=%0d busy=%0b, required vector %0d busy=1",
                         name, n, a_out, b_out, busy, k);
            end
        end
        compared++;
        if (bad_vec) mismatched++;
        compared++;
        if (n != SWEEP) begin
            mismatched++;
            $display("FAIL %s_done_edge: done after %0d edges, required %0d", name, n, SWEEP);
        end
        compared++;
        if (done !== 1 || busy !== 0 || a_out !== 3'd7 || b_out !== 3'd7) begin
            mismatched++;
            $display("FAIL %s_done_state: done=%0b busy=%0b a=%0d b=%0d, required 1 0 7 7",
                     name, done, busy, a_out, b_out);
        end
        compared++;
        if (mismatch_cnt !== exp_cnt) begin
            mismatched++;
            $display("FAIL %s_count: cnt=%0d, required %0d", name, mismatch_cnt, exp_cnt);
        end
        compared++;
        if (first < 0) begin
            if (first_fail_valid !== 0 || first_fail_a !== 0 || first_fail_b !== 0 || first_fail_diff !== 0) begin
                mismatched++;
                $display("FAIL %s_first: ffv=%0b a=%0d b=%0d diff=%0d, required none",
                         name, first_fail_valid, first_fail_a, first_fail_b, first_fail_diff);
            end
        end else if (first_fail_valid !== 1 || first_fail_a !== W'(first >> W) ||
                     first_fail_b !== W'(first) || first_fail_diff !== fault_tab[first]) begin
            mismatched++;
            $display("FAIL %s_first: ffv=%0b a=%0d b=%0d diff=%0d, required 1 %0d %0d %0d",
                     name, first_fail_valid, first_fail_a, first_fail_b, first_fail_diff,
                     first >> W, first & (NV / (1 << W) - 1), fault_tab[first]);
        end
        $display("sweep %s: edges=%0d cnt=%0d expected_cnt=%0d first_idx=%0d", name, n, mismatch_cnt, exp_cnt, first);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        tick();
        tick();
        check_reset_values("reset_with_start");
        rst = 1'b0;
        start = 1'b0;
        tick();
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_equal();
        set_faults(0);
        run_sweep("equal", 0);
    endtask

    task automatic test_single_fault();
        set_faults(1);
        run_sweep("single_5_2", 0);
    endtask

    task automatic test_all_fault();
        set_faults(2);
        run_sweep("all_bit2", 0);
        repeat (3) tick();
        compared++;
        if (done !== 1 || mismatch_cnt !== NV) begin
            mismatched++;
            $display("FAIL done_hold: done=%0b cnt=%0d, required 1 %0d", done, mismatch_cnt, NV);
        end
    endtask

    task automatic test_restart_from_done();
        set_faults(0);
        run_sweep("restart_equal", 0);
    endtask

    task automatic test_start_ignored();
        set_faults(1);
        run_sweep("repulse50", 50);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            set_faults(3);
            run_sweep($sformatf("random%0d", r), 0);
        end
    endtask

    task automatic test_mid_reset();
        set_faults(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        compared++;
        if (mismatch_cnt !== 33 || busy !== 1) begin
            mismatched++;
            $display("FAIL pre_reset: cnt=%0d busy=%0b, required 33 1", mismatch_cnt, busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_values("mid_reset");
        repeat (5) tick();
        check_reset_values("idle_hold");
        set_faults(3);
        run_sweep("after_reset", 0);
    endtask

    initial begin
        set_faults(0);
        test_reset();
        test_equal();
        test_single_fault();
        test_all_fault();
        test_restart_from_done();
        test_start_ignored();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
